// File: rtl/pc16.sv
// 16-bit program counter: register with a CLR > LOAD > INC > hold mux chain in front,
// a half-adder ripple incrementer and a registered one-cycle WRAP flag.
module pc16 #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD,
  input  logic             INC,
  input  logic             CLR,
  output logic [WIDTH-1:0] OUT,
  output logic             WRAP
);

  logic [WIDTH-1:0] inc_sum;
  logic             c_out;
  logic [WIDTH-1:0] sel_inc;
  logic [WIDTH-1:0] sel_load;
  logic [WIDTH-1:0] sel_clr;
  logic             wrap_nxt;

  function automatic logic [WIDTH-1:0] mux_w(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sel);
    mux_w = sel ? b : a;
  endfunction

  // Half-adder ripple with carry-in tied high; c_out is set only when OUT is all ones.
  always_comb begin
    logic c;
    c       = 1'b1;
    inc_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc_sum[i] = OUT[i] ^ c;
      c          = OUT[i] & c;
    end
    c_out = c;
  end

  assign sel_inc  = mux_w(OUT, inc_sum, INC);
  assign sel_load = mux_w(sel_inc, IN, LOAD);
  assign sel_clr  = mux_w(sel_load, RESET_VALUE, CLR);
  assign wrap_nxt = INC & ~LOAD & ~CLR & c_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT  <= RESET_VALUE;
      WRAP <= 1'b0;
    end else begin
      OUT  <= sel_clr;
      WRAP <= wrap_nxt;
    end
  end

endmodule
